// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4
  } parser_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_gap_timer.sv
// Inter-byte gap counter: cleared by clear, counts while enabled, flags the
// expiry cycle. Clear has priority so a byte arriving on expiry wins.
module uart_gap_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles header/CMD/LEN/payload/checksum frames from a UART byte stream.
// Define UART_PARSER_TIMEOUT_EN to abort frames on an inter-byte gap.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd_out,
  output logic [7:0] len_out,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic [7:0] pl_idx,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_e state_q, state_d;
  logic [7:0] cmd_q, cmd_d, len_q, len_d;
  logic [7:0] pl_data_q, pl_data_d, pl_idx_q, pl_idx_d;
  logic       pl_valid_q, pl_valid_d, frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d, busy_q, busy_d;
  logic [1:0] err_code_q, err_code_d;
  logic [7:0] sum_q, sum_d, idx_q, idx_d;
  logic       timeout_expire;

`ifdef UART_PARSER_TIMEOUT_EN
  uart_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rx_valid || (state_q == HUNT)),
    .enable(state_q != HUNT),
    .expire(timeout_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        HUNT:    if (rx_data == HEADER) state_d = CMD;
        CMD:     state_d = LEN;
        LEN: begin
          if (rx_data > MAX_LEN_B)   state_d = HUNT;
          else if (rx_data == 8'd0)  state_d = CHK;
          else                       state_d = PAYLOAD;
        end
        PAYLOAD: if (idx_q == len_q - 8'd1) state_d = CHK;
        CHK:     state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end else if (timeout_expire) begin
      state_d = HUNT;
    end
  end

  // Output and datapath next values; everything lands in flops one clk later.
  always_comb begin
    cmd_d       = cmd_q;
    len_d       = len_q;
    pl_data_d   = pl_data_q;
    pl_idx_d    = pl_idx_q;
    pl_valid_d  = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    busy_d      = (state_d != HUNT);
    if (rx_valid) begin
      case (state_q)
        CMD: begin
          cmd_d = rx_data;
          sum_d = rx_data;
        end
        LEN: begin
          len_d = rx_data;
          sum_d = sum_q + rx_data;
          idx_d = 8'd0;
          if (rx_data > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
        end
        PAYLOAD: begin
          pl_data_d  = rx_data;
          pl_valid_d = 1'b1;
          pl_idx_d   = idx_q;
          sum_d      = sum_q + rx_data;
          idx_d      = idx_q + 8'd1;
        end
        CHK: begin
          if (rx_data == sum_q) begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
        default: ;
      endcase
    end else if (timeout_expire) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      len_q       <= '0;
      pl_data_q   <= '0;
      pl_idx_q    <= '0;
      pl_valid_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      sum_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      pl_data_q   <= pl_data_d;
      pl_idx_q    <= pl_idx_d;
      pl_valid_q  <= pl_valid_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_out   = cmd_q;
  assign len_out   = len_q;
  assign pl_data   = pl_data_q;
  assign pl_idx    = pl_idx_q;
  assign pl_valid  = pl_valid_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized and directed bench for uart_frame_parser against a frame-level
// reference model that scans the byte stream for whole frames.
module tb_uart_frame_parser;

  localparam logic [7:0] HDR     = 8'hA5;
  localparam int         MAXL    = 16;
  localparam int         TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] cmd_out, len_out, pl_data, pl_idx;
  logic       pl_valid, frame_ok, frame_err, busy;
  logic [1:0] err_code;

  uart_frame_parser #(
    .HEADER     (HDR),
    .MAX_LEN    (MAXL),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_out  (cmd_out),
    .len_out  (len_out),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_idx   (pl_idx),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ev;     // {pl_valid, frame_ok, frame_err}
    logic [7:0] data;
    logic [7:0] idx;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [1:0] err;
    logic       busy;
  } exp_t;

  logic [7:0] stim_q[$];
  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         max_gap = 3;
  logic [7:0] m_cmd, m_len;
  logic [1:0] m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic void push_exp(input logic [2:0] ev, input logic [7:0] d,
                                   input logic [7:0] ix, input logic b);
    exp_t e;
    e.ev = ev; e.data = d; e.idx = ix;
    e.cmd = m_cmd; e.len = m_len; e.err = m_err; e.busy = b;
    exp_q.push_back(e);
  endfunction

  // Walk the stream frame by frame and emit the expected response per byte.
  function automatic void build_model();
    int i = 0;
    int n = stim_q.size();
    int sum;
    exp_q.delete();
    m_cmd = 8'h00; m_len = 8'h00; m_err = 2'd0;
    while (i < n) begin
      if (stim_q[i] != HDR) begin
        push_exp(3'b000, 8'h00, 8'h00, 1'b0);
        i++;
        continue;
      end
      push_exp(3'b000, 8'h00, 8'h00, 1'b1);
      i++;
      if (i >= n) break;
      m_cmd = stim_q[i];
      push_exp(3'b000, 8'h00, 8'h00, 1'b1);
      i++;
      if (i >= n) break;
      m_len = stim_q[i];
      i++;
      sum = int'(m_cmd) + int'(m_len);
      if (int'(m_len) > MAXL) begin
        m_err = 2'd2;
        push_exp(3'b001, 8'h00, 8'h00, 1'b0);
        continue;
      end
      push_exp(3'b000, 8'h00, 8'h00, 1'b1);
      for (int k = 0; k < int'(m_len) && i < n; k++) begin
        push_exp(3'b100, stim_q[i], 8'(k), 1'b1);
        sum += int'(stim_q[i]);
        i++;
      end
      if (i >= n) break;
      if (int'(stim_q[i]) == (sum % 256)) begin
        m_err = 2'd0;
        push_exp(3'b010, 8'h00, 8'h00, 1'b0);
      end else begin
        m_err = 2'd1;
        push_exp(3'b001, 8'h00, 8'h00, 1'b0);
      end
      i++;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("reset_outputs",
              {cmd_out, len_out, pl_data, pl_idx, pl_valid, frame_ok, frame_err, err_code, busy},
              32'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_byte(input int i);
    exp_t e = exp_q[i];
    check_val($sformatf("b%0d_pulses", i), {29'd0, pl_valid, frame_ok, frame_err}, {29'd0, e.ev});
    check_val($sformatf("b%0d_cmd", i), {24'd0, cmd_out}, {24'd0, e.cmd});
    check_val($sformatf("b%0d_len", i), {24'd0, len_out}, {24'd0, e.len});
    check_val($sformatf("b%0d_err_code", i), {30'd0, err_code}, {30'd0, e.err});
    check_val($sformatf("b%0d_busy", i), {31'd0, busy}, {31'd0, e.busy});
    if (e.ev[2]) begin
      check_val($sformatf("b%0d_pl_data", i), {24'd0, pl_data}, {24'd0, e.data});
      check_val($sformatf("b%0d_pl_idx", i), {24'd0, pl_idx}, {24'd0, e.idx});
    end
  endtask

  task automatic run_stream(input string name);
    int gap;
    do_reset();
    build_model();
    $display("stream %s: %0d bytes, max_gap %0d", name, stim_q.size(), max_gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        @(negedge clk);
        check_val("idle_pulses", {29'd0, pl_valid, frame_ok, frame_err}, 32'd0);
      end
      rx_data = stim_q[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check_byte(i);
    end
    @(negedge clk);
    check_val("tail_pulses", {29'd0, pl_valid, frame_ok, frame_err}, 32'd0);
  endtask

  task automatic add_random_frame();
    int len;
    int sum;
    logic [7:0] b;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == HDR) b = 8'h00;
      stim_q.push_back(b);
    end
    stim_q.push_back(HDR);
    b = 8'($urandom_range(0, 255));
    stim_q.push_back(b);
    sum = int'(b);
    len = ($urandom_range(0, 9) < 8) ? $urandom_range(0, MAXL) : $urandom_range(MAXL + 1, 255);
    stim_q.push_back(8'(len));
    sum += len;
    if (len > MAXL) return;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      stim_q.push_back(b);
      sum += int'(b);
    end
    if ($urandom_range(0, 9) < 7) stim_q.push_back(8'(sum));
    else stim_q.push_back(8'(sum + $urandom_range(1, 255)));
  endtask

  initial begin
    int err_pulses;
    logic [1:0] err_seen;

    for (int pass = 0; pass < 2; pass++) begin
      max_gap = (pass == 0) ? 3 : 0;
      stim_q = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h36};
      run_stream("good_frame");
      stim_q = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h37};
      run_stream("bad_checksum");
      stim_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07, 8'h00, 8'h07};
      run_stream("junk_then_zero_len");
      stim_q = '{8'hA5, 8'h03, 8'h20, 8'hA5, 8'h03, 8'h01, 8'hAA, 8'hAE};
      run_stream("len_too_big_then_ok");
      stim_q = '{8'hA5, 8'h01, 8'h02, 8'h11};
      run_stream("partial_then_reset");
      stim_q = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h36};
      run_stream("after_reset");
    end

    max_gap = 2;
    for (int s = 0; s < 20; s++) begin
      stim_q.delete();
      repeat (4) add_random_frame();
      run_stream($sformatf("random_%0d", s));
    end

    // Inter-byte gap behaviour after a partial frame.
    max_gap = 0;
    stim_q = '{8'hA5, 8'h01, 8'h02, 8'h11};
    run_stream("gap_wait");
    err_pulses = 0;
    err_seen = 2'd0;
    for (int c = 0; c < TIMEOUT + 10; c++) begin
      @(negedge clk);
      if (frame_err) begin
        err_pulses++;
        err_seen = err_code;
      end
      check_val("gap_no_ok", {31'd0, frame_ok}, 32'd0);
    end
`ifdef UART_PARSER_TIMEOUT_EN
    check_val("timeout_err_pulses", err_pulses, 32'd1);
    check_val("timeout_err_code", {30'd0, err_seen}, 32'd3);
    check_val("timeout_busy", {31'd0, busy}, 32'd0);
`else
    check_val("no_timeout_err_pulses", err_pulses, 32'd0);
    check_val("no_timeout_busy", {31'd0, busy}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Consumes the byte stream from the UART receiver (8-bit data plus a one-cycle valid pulse) and assembles command frames. Frame format: header, CMD, LEN, LEN payload bytes, checksum.
- Payload bytes are streamed out as they arrive.
- Frame acceptance or rejection is signalled when the checksum byte lands.
- Sits between the UART receiver and the register/command decoder.

Parameters:
HEADER, 8'hA5, start-of-frame byte
MAX_LEN, 16, largest legal LEN value (1..255)
TIMEOUT_CYC, 50000, max clk cycles between bytes inside a frame (1 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
cmd_out  out  8  CMD byte of current frame, held until next frame's CMD
len_out  out  8  LEN byte of current frame, held likewise
pl_data  out  8  payload byte
pl_valid  out  1  one-cycle strobe for pl_data
pl_idx  out  8  index of pl_data within payload, 0-based
frame_ok  out  1  one-cycle pulse, checksum matched
frame_err  out  1  one-cycle pulse, frame aborted
err_code  out  2  0 none, 1 checksum, 2 length, 3 timeout; valid with frame_err, held until next frame_err/frame_ok (ok clears to 0)
busy  out  1  high in any state except HUNT

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk.
  - All outputs are 0 in reset. State returns to HUNT. Checksum and counters are cleared.
  - Reset mid-frame discards the partial frame with no pulse.
- All outputs are registered. Latency is 1 clk from rx_valid to pl_valid, frame_ok or frame_err.
- rx_valid may be asserted on consecutive cycles. Every strobe is consumed and nothing is dropped.
- HUNT:
  - A byte equal to HEADER goes to CMD. Any other byte is ignored silently.
- CMD:
  - Latch cmd_out.
  - sum = byte.
  - Go to LEN.
- LEN:
  - Latch len_out.
  - sum += byte.
  - LEN > MAX_LEN: frame_err, err_code=2, go to HUNT.
  - LEN == 0: go to CHK.
  - Otherwise go to PAYLOAD with idx=0.
- PAYLOAD:
  - Per byte: pl_data=byte, pl_valid=1, pl_idx=idx, sum += byte, idx++.
  - After the byte with idx == LEN-1, go to CHK.
  - HEADER value inside the payload is ordinary data; there is no resync.
- CHK:
  - byte == sum[7:0]: frame_ok.
  - Otherwise frame_err with err_code=1.
  - Go to HUNT in either case.
- Arithmetic: sum is 8-bit, modulo 256, wraps silently. idx is 8-bit.
- The consumer must buffer payload and discard it on frame_err. Payload is not withheld pending the checksum.
- frame_ok and frame_err are never asserted together. busy drops the cycle after either pulse.

Optional Feature:
- Macro UART_PARSER_TIMEOUT_EN, when defined:
  - A gap counter runs in every state except HUNT. It is cleared on each rx_valid.
  - Reaching TIMEOUT_CYC-1 without a byte gives frame_err, err_code=3, and returns to HUNT.
  - If rx_valid arrives in the same cycle as expiry, the byte wins and no timeout is raised.
- When undefined: no counter logic; the parser waits indefinitely; err_code 3 is never produced.

Decomposition:
- Package uart_frame_pkg holds:
  - state encoding: HUNT, CMD, LEN, PAYLOAD, CHK
  - err_code constants: ERR_NONE, ERR_CHK, ERR_LEN, ERR_TIMEOUT
  - default HEADER value
- One sub-module, uart_gap_timer: clear/enable/expire counter, instantiated only under UART_PARSER_TIMEOUT_EN.

Test Plan:
- Frame A5 01 02 11 22 36 → cmd_out=01, len_out=02; pl_valid twice with (11, idx0) then (22, idx1); frame_ok after 36; err_code=0.
- Frame A5 01 02 11 22 37 → both payload strobes; frame_err, err_code=1; no frame_ok.
- Junk 00 FF 5A then A5 07 00 07 → junk ignored, busy stays 0; zero-length frame gives frame_ok with no pl_valid.
- A5 03 20 with MAX_LEN=16 → frame_err, err_code=2 one cycle after the 20. A following A5 03 01 AA AE gives frame_ok.
- A5 01 02 11, then no bytes for TIMEOUT_CYC cycles (macro on) → frame_err, err_code=3, busy=0. Macro off → still busy, no pulse.
- rst_n pulsed after A5 01 02 11 → outputs 0, no pulse. The next full frame A5 01 02 11 22 36 completes with frame_ok. Back-to-back rx_valid strobes give identical results.
